// File: rtl/l2_mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_mem_port_arbiter_if
//   Bundles the bank-side and memory-side signals of the L2 memory port
//   arbiter. The parameters must match those of the arbiter it is bound to.
//
//   Modports:
//     slave  : arbiter view. It takes bank requests and memory responses,
//              and it drives bank completions and the memory request.
//     master : environment view. Bank controllers and the memory/interconnect
//              model drive requests and responses here.
//
//   Signals:
//     bank_req   [NUM_BANKS]             per-bank request, held until bank_ack
//     bank_we    [NUM_BANKS]             1 = writeback (evict), 0 = fill
//     bank_addr  [NUM_BANKS*PADDR_WIDTH] bank i at [i*PADDR_WIDTH +: PADDR_WIDTH]
//     bank_wdata [NUM_BANKS*LINE_BITS]   bank i at [i*LINE_BITS +: LINE_BITS]
//     bank_ack   [NUM_BANKS]             1-cycle completion pulse
//     bank_error [NUM_BANKS]             1-cycle error pulse, same cycle as bank_ack
//     bank_rdata [LINE_BITS]             fill data, valid while bank_ack is high
//     mem_req                            level request, held until mem_ack/mem_error
//     mem_we, mem_addr, mem_wdata        memory command and write data
//     mem_ack, mem_rdata                 memory completion and read data
//     mem_error                          memory error, ends the transaction
//     timeout_o                          1-cycle pulse on a timeout kill
// ---------------------------------------------------------------------------
interface l2_mem_port_arbiter_if #(
  parameter int NUM_BANKS   = 4,
  parameter int PADDR_WIDTH = 56,
  parameter int LINE_BITS   = 512
);
  logic [NUM_BANKS-1:0]             bank_req;
  logic [NUM_BANKS-1:0]             bank_we;
  logic [NUM_BANKS*PADDR_WIDTH-1:0] bank_addr;
  logic [NUM_BANKS*LINE_BITS-1:0]   bank_wdata;
  logic [NUM_BANKS-1:0]             bank_ack;
  logic [NUM_BANKS-1:0]             bank_error;
  logic [LINE_BITS-1:0]             bank_rdata;
  logic                             mem_req;
  logic                             mem_we;
  logic [PADDR_WIDTH-1:0]           mem_addr;
  logic [LINE_BITS-1:0]             mem_wdata;
  logic                             mem_ack;
  logic [LINE_BITS-1:0]             mem_rdata;
  logic                             mem_error;
  logic                             timeout_o;

  modport slave (
    input  bank_req, bank_we, bank_addr, bank_wdata,
    input  mem_ack, mem_rdata, mem_error,
    output bank_ack, bank_error, bank_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, timeout_o
  );

  modport master (
    output bank_req, bank_we, bank_addr, bank_wdata,
    output mem_ack, mem_rdata, mem_error,
    input  bank_ack, bank_error, bank_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, timeout_o
  );
endinterface

// File: rtl/l2_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// l2_mem_port_arbiter
//   Shares the single line-wide memory port among NUM_BANKS L2 bank
//   controllers. It uses round-robin arbitration and allows one outstanding
//   transaction. The grant is held from request to mem_ack, mem_error or
//   timeout. Fill data is registered and returned to the granted bank.
//
//   Handshake (request/acknowledge, level/pulse):
//     A bank raises bank_req[i] and holds it, along with bank_we/addr/wdata,
//     until it samples bank_ack[i]. It drops bank_req on that same edge.
//     bank_ack is a single-cycle pulse. bank_error and bank_rdata are
//     qualified by that pulse.
//     On the memory side, mem_req is a level. It is held with stable
//     mem_we/addr/wdata until the cycle mem_ack or mem_error is seen.
//     mem_ack and mem_error are ignored unless a transaction is outstanding.
//
//   Ports:
//     clk        clock
//     rst_n      asynchronous, active-low reset
//     bus        l2_mem_port_arbiter_if.slave (bank and memory signals)
//     state_dbg  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module l2_mem_port_arbiter #(
  parameter int NUM_BANKS      = 4,
  parameter int PADDR_WIDTH    = 56,
  parameter int LINE_BITS      = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  l2_mem_port_arbiter_if.slave        bus,
  output logic [1:0]                  state_dbg
);

  localparam int IDXW = $clog2(NUM_BANKS);
  // The counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNTW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST =
    CNTW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDXW-1:0]        grant_q;
  logic [IDXW-1:0]        rr_ptr_q;
  logic                   we_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [LINE_BITS-1:0]   wdata_q;
  logic [LINE_BITS-1:0]   rdata_q;
  logic                   err_q;
  logic                   to_q;
  logic [CNTW-1:0]        cnt_q;

  // -------------------------------------------------------------------------
  // Round-robin pick: the first requester at or after rr_ptr, moving upward
  // and wrapping. The loop runs from the farthest offset to the nearest, so
  // the nearest requester is written last and wins. The index sum wraps
  // naturally because NUM_BANKS is a power of two.
  // -------------------------------------------------------------------------
  logic            pick_valid;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      cand = rr_ptr_q + IDXW'(i);
      if (bus.bank_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // -------------------------------------------------------------------------
  // BUSY exit causes, in priority order: error, then ack, then timeout.
  // Because ack outranks timeout, an ack on the last allowed cycle still
  // completes cleanly.
  // -------------------------------------------------------------------------
  logic busy_err, busy_ack, busy_to;

  assign busy_err = bus.mem_error;
  assign busy_ack = !bus.mem_error && bus.mem_ack;
  assign busy_to  = TO_EN && !bus.mem_error && !bus.mem_ack && (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_BUSY;
      S_BUSY:  if (busy_err || busy_ack || busy_to) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: the grant latch, the transaction counter, the
  // completion status and the fill-data register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            we_q    <= bus.bank_we[pick_idx];
            addr_q  <= bus.bank_addr[pick_idx*PADDR_WIDTH +: PADDR_WIDTH];
            wdata_q <= bus.bank_wdata[pick_idx*LINE_BITS +: LINE_BITS];
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (busy_err) begin
            err_q <= 1'b1;
          end else if (busy_ack) begin
            err_q <= 1'b0;
            // A writeback leaves the last fill data in place.
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else if (busy_to) begin
            err_q <= 1'b1;
            to_q  <= 1'b1;
          end
        end
        S_DONE: begin
          rr_ptr_q <= grant_q + 1'b1;
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. All outputs decode from the state, so an asynchronous
  // reset drops mem_req at once and no completion can follow it.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.bank_ack   = '0;
    bus.bank_error = '0;
    bus.timeout_o  = 1'b0;
    bus.bank_rdata = rdata_q;
    unique case (state_q)
      S_BUSY: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
      end
      S_DONE: begin
        bus.bank_ack[grant_q]   = 1'b1;
        bus.bank_error[grant_q] = err_q;
        bus.timeout_o           = to_q;
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;

  // -------------------------------------------------------------------------
  // Interface invariants
  // -------------------------------------------------------------------------
  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.bank_ack));
  a_ack_in_done: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.bank_ack != '0) |-> (state_q == S_DONE));
  a_err_with_ack: assert property (@(posedge clk) disable iff (!rst_n)
    ((bus.bank_error & ~bus.bank_ack) == '0));
  a_req_only_busy: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mem_req |-> (state_q == S_BUSY));

endmodule

// File: tb/tb_l2_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_mem_port_arbiter
//   Scenario-driven bench for the L2 memory port arbiter (4 banks, 8-cycle
//   timeout). Expected completions {bank, err, rdata} go into exp_q when a
//   request is driven. They are popped and compared when bank_ack appears.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_l2_mem_port_arbiter;
  localparam int N  = 4;
  localparam int P  = 56;
  localparam int L  = 512;
  localparam int T  = 8;
  localparam int SB_W = 2 + 1 + L;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  l2_mem_port_arbiter_if #(.NUM_BANKS(N), .PADDR_WIDTH(P), .LINE_BITS(L)) bus ();

  l2_mem_port_arbiter #(
    .NUM_BANKS(N), .PADDR_WIDTH(P), .LINE_BITS(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  logic [SB_W-1:0] exp_q[$];
  logic [SB_W-1:0] e;
  logic [L-1:0]    last_rdata;
  int              n_checks = 0;
  int              n_pass   = 0;

  function automatic logic [SB_W-1:0] sb_entry(input int b, input logic err,
                                               input logic [L-1:0] d);
    return {2'(b), err, d};
  endfunction

  function automatic logic [N-1:0] onehot(input logic [1:0] i);
    logic [N-1:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic logic [L-1:0] rand_line();
    logic [L-1:0] v;
    for (int w = 0; w < L / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.bank_req   = '0;
    bus.bank_we    = '0;
    bus.bank_addr  = '0;
    bus.bank_wdata = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_error  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) step();
    rst_n = 1'b1;
    last_rdata = '0;
    step();
  endtask

  task automatic set_bank(input int b, input logic we, input logic [P-1:0] a,
                          input logic [L-1:0] d);
    bus.bank_we[b]            = we;
    bus.bank_addr[b*P +: P]   = a;
    bus.bank_wdata[b*L +: L]  = d;
  endtask

  // Waits for mem_req, for at most max cycles.
  task automatic wait_req(input int max, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < max && !seen; c++) begin
      step();
      if (bus.mem_req === 1'b1) seen = 1'b1;
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    n_checks++;
    if (state_dbg !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_dbg);
    else n_pass++;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.timeout_o} !== 3'b000)
      $display("FAIL rst_mem_ctl: got %b want 000", {bus.mem_req, bus.mem_we, bus.timeout_o});
    else n_pass++;
    n_checks++;
    if ({bus.bank_ack, bus.bank_error} !== 8'h00)
      $display("FAIL rst_bank_ack: got %h want 00", {bus.bank_ack, bus.bank_error});
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== '0 || bus.bank_rdata !== '0)
      $display("FAIL rst_data: got addr %h want 0", bus.mem_addr);
    else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_single_read();
    logic [L-1:0] pat;
    pat = {64{8'hA5}};
    set_bank(2, 1'b0, 56'h1000, '0);
    bus.bank_req = 4'b0100;
    exp_q.push_back(sb_entry(2, 1'b0, pat));
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 56'h1000)
        $display("FAIL rd_busy_c%0d: got req %b we %b addr %h want 1 0 1000",
                 c, bus.mem_req, bus.mem_we, bus.mem_addr);
      else n_pass++;
      if (c == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = pat;
      end
    end
    step();
    bus.mem_ack  = 1'b0;
    bus.bank_req = '0;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) || bus.bank_error !== 4'b0000)
      $display("FAIL rd_ack: got ack %b err %b want 0100 0000", bus.bank_ack, bus.bank_error);
    else n_pass++;
    n_checks++;
    if (bus.bank_rdata !== e[L-1:0])
      $display("FAIL rd_data: got %h want %h", bus.bank_rdata, e[L-1:0]);
    else n_pass++;
    last_rdata = pat;
    step();
    n_checks++;
    if (bus.bank_ack !== 4'b0000 || bus.mem_req !== 1'b0)
      $display("FAIL rd_after: got ack %b req %b want 0000 0", bus.bank_ack, bus.mem_req);
    else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_round_robin();
    logic [P-1:0] addr_tab[N];
    logic [L-1:0] d;
    int           order[5];
    bit           seen;
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int b = 0; b < N; b++) begin
      addr_tab[b] = 56'h2000 + P'(b * 64);
      set_bank(b, 1'b0, addr_tab[b], '0);
    end
    for (int t = 0; t < 5; t++)
      exp_q.push_back(sb_entry(order[t], 1'b0, {16{32'hC0DE_0000 | t}}));
    bus.bank_req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_req(10, seen);
      n_checks++;
      if (!seen) $display("FAIL rr_req_t%0d: got no mem_req want mem_req within 10 cycles", t);
      else n_pass++;
      if (seen) begin
        e = exp_q[0];
        n_checks++;
        if (bus.mem_addr !== addr_tab[e[SB_W-1 -: 2]])
          $display("FAIL rr_addr_t%0d: got %h want %h", t, bus.mem_addr, addr_tab[e[SB_W-1 -: 2]]);
        else n_pass++;
        d = {16{32'hC0DE_0000 | t}};
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        step();
        bus.mem_ack = 1'b0;
        if (t == 4) bus.bank_req = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) || bus.bank_error !== 4'b0000)
          $display("FAIL rr_ack_t%0d: got ack %b err %b want %b 0000",
                   t, bus.bank_ack, bus.bank_error, onehot(e[SB_W-1 -: 2]));
        else n_pass++;
        n_checks++;
        if (bus.bank_rdata !== e[L-1:0])
          $display("FAIL rr_data_t%0d: got %h want %h", t, bus.bank_rdata, e[L-1:0]);
        else n_pass++;
        last_rdata = d;
      end
    end
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_writeback();
    logic [L-1:0] p;
    p = rand_line();
    set_bank(1, 1'b1, 56'h3000, p);
    bus.bank_req = 4'b0010;
    exp_q.push_back(sb_entry(1, 1'b0, last_rdata));
    for (int c = 1; c <= 3; c++) begin
      step();
      n_checks++;
      if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_wdata !== p || bus.mem_addr !== 56'h3000)
        $display("FAIL wb_busy_c%0d: got req/we %b addr %h want 11 3000", c,
                 {bus.mem_req, bus.mem_we}, bus.mem_addr);
      else n_pass++;
      if (c == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ~p;
      end
    end
    step();
    bus.mem_ack  = 1'b0;
    bus.bank_req = '0;
    bus.bank_we  = '0;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) || bus.bank_error !== 4'b0000)
      $display("FAIL wb_ack: got ack %b err %b want 0010 0000", bus.bank_ack, bus.bank_error);
    else n_pass++;
    n_checks++;
    if (bus.bank_rdata !== e[L-1:0])
      $display("FAIL wb_rdata_kept: got %h want %h", bus.bank_rdata, e[L-1:0]);
    else n_pass++;
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_timeout();
    logic [L-1:0] r;
    int           n_busy;
    bit           seen;
    set_bank(3, 1'b0, 56'h4000, '0);
    set_bank(0, 1'b0, 56'h5000, '0);
    bus.bank_req = 4'b1001;
    exp_q.push_back(sb_entry(3, 1'b1, last_rdata));
    n_busy = 0;
    seen   = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (bus.mem_req === 1'b1) n_busy++;
      if (bus.bank_ack !== 4'b0000) seen = 1'b1;
    end
    bus.bank_req = 4'b0001;
    n_checks++;
    if (!seen || n_busy != T)
      $display("FAIL to_busy_len: got seen %0d busy %0d want 1 %0d", seen, n_busy, T);
    else n_pass++;
    n_checks++;
    if (bus.timeout_o !== 1'b1)
      $display("FAIL to_pulse: got %b want 1", bus.timeout_o);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) ||
        bus.bank_error !== (e[L] ? onehot(e[SB_W-1 -: 2]) : 4'b0000))
      $display("FAIL to_ack: got ack %b err %b want 1000 1000", bus.bank_ack, bus.bank_error);
    else n_pass++;

    // Next requester (bank0), this time acked on the final allowed cycle.
    r = rand_line();
    exp_q.push_back(sb_entry(0, 1'b0, r));
    n_busy = 0;
    seen   = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (bus.bank_ack !== 4'b0000) seen = 1'b1;
      else if (bus.mem_req === 1'b1) begin
        n_busy++;
        if (n_busy == T) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = r;
        end
      end
    end
    bus.mem_ack  = 1'b0;
    bus.bank_req = '0;
    n_checks++;
    if (!seen || n_busy != T)
      $display("FAIL to_last_len: got seen %0d busy %0d want 1 %0d", seen, n_busy, T);
    else n_pass++;
    n_checks++;
    if (bus.timeout_o !== 1'b0)
      $display("FAIL to_last_pulse: got %b want 0", bus.timeout_o);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) || bus.bank_error !== 4'b0000 ||
        bus.bank_rdata !== e[L-1:0])
      $display("FAIL to_last_ack: got ack %b err %b want 0001 0000", bus.bank_ack, bus.bank_error);
    else n_pass++;
    last_rdata = r;
    step();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_mem_error();
    set_bank(2, 1'b0, 56'h6000, '0);
    bus.bank_req = 4'b0100;
    exp_q.push_back(sb_entry(2, 1'b1, last_rdata));
    step();
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 56'h6000)
      $display("FAIL err_busy: got req %b addr %h want 1 6000", bus.mem_req, bus.mem_addr);
    else n_pass++;
    bus.mem_error = 1'b1;
    bus.mem_rdata = rand_line();
    step();
    bus.mem_error = 1'b0;
    bus.bank_req  = '0;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) || bus.bank_error !== onehot(e[SB_W-1 -: 2]))
      $display("FAIL err_ack: got ack %b err %b want 0100 0100", bus.bank_ack, bus.bank_error);
    else n_pass++;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.timeout_o !== 1'b0 || bus.bank_rdata !== e[L-1:0])
      $display("FAIL err_side: got req %b to %b want 0 0", bus.mem_req, bus.timeout_o);
    else n_pass++;
    step();
    // Stray responses while idle must do nothing.
    bus.mem_ack   = 1'b1;
    bus.mem_error = 1'b1;
    bus.mem_rdata = rand_line();
    for (int c = 0; c < 2; c++) begin
      step();
      n_checks++;
      if (bus.bank_ack !== 4'b0000 || state_dbg !== 2'd0)
        $display("FAIL stray_ack_c%0d: got ack %b state %0d want 0000 0", c, bus.bank_ack, state_dbg);
      else n_pass++;
    end
    bus.mem_ack   = 1'b0;
    bus.mem_error = 1'b0;
    step();
    n_checks++;
    if (bus.bank_rdata !== last_rdata)
      $display("FAIL stray_rdata: got %h want %h", bus.bank_rdata, last_rdata);
    else n_pass++;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset_mid_busy();
    logic [L-1:0] d;
    bit           seen;
    set_bank(1, 1'b0, 56'h7000, '0);
    bus.bank_req = 4'b0010;
    step();
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1)
      $display("FAIL mrst_pre: got req %b want 1", bus.mem_req);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || state_dbg !== 2'd0)
      $display("FAIL mrst_async: got req %b state %0d want 0 0", bus.mem_req, state_dbg);
    else n_pass++;
    bus.bank_req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus.bank_ack !== 4'b0000)
        $display("FAIL mrst_no_ack_c%0d: got %b want 0000", c, bus.bank_ack);
      else n_pass++;
    end
    rst_n      = 1'b1;
    last_rdata = '0;
    step();
    n_checks++;
    if (bus.bank_rdata !== last_rdata || bus.bank_ack !== 4'b0000)
      $display("FAIL mrst_regs: got ack %b want 0000 and zero rdata", bus.bank_ack);
    else n_pass++;
    // rr_ptr is back at 0, so bank0 wins over bank3.
    set_bank(0, 1'b0, 56'h8000, '0);
    set_bank(3, 1'b0, 56'h9000, '0);
    d = rand_line();
    exp_q.push_back(sb_entry(0, 1'b0, d));
    bus.bank_req = 4'b1001;
    wait_req(10, seen);
    n_checks++;
    if (!seen || bus.mem_addr !== 56'h8000)
      $display("FAIL mrst_prio: got seen %0d addr %h want 1 8000", seen, bus.mem_addr);
    else n_pass++;
    if (seen) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = d;
      step();
      bus.mem_ack  = 1'b0;
      bus.bank_req = '0;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.bank_ack !== onehot(e[SB_W-1 -: 2]) || bus.bank_rdata !== e[L-1:0])
        $display("FAIL mrst_ack: got ack %b want %b", bus.bank_ack, onehot(e[SB_W-1 -: 2]));
      else n_pass++;
      last_rdata = d;
    end
    step();
  endtask

  // -------------------------------------------------------------------------
  initial begin
    do_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_writeback();
    test_timeout();
    test_mem_error();
    test_reset_mid_busy();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit, in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
